// File: rtl/mem_wb_stage.sv
// MEM/WB register + load formatting; writeback/forwarding 1 cycle after capture, combinational from regs and read_data.
// stall holds the stage (read word latched once so it can't drift); flush inserts a bubble; instret counts commits.
module mem_wb_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    input  logic             in_mem_read,
    input  logic [2:0]       in_load_type,
    input  logic [31:0]      in_result,
    input  logic [31:0]      read_data,
    output logic             wb_en,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data,
    output logic             misaligned_load,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    logic        valid_q;
    logic [4:0]  rd_q;
    logic        reg_write_q;
    logic        mem_read_q;
    logic [2:0]  load_type_q;
    logic [31:0] result_q;
    logic        hold_valid;
    logic [31:0] data_hold;

    logic        commit;
    logic [1:0]  off;
    logic [31:0] load_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;
    logic [31:0] wr_data;
    logic        is_half;
    logic        is_word;
    logic        writes_rd;

    assign commit = valid_q & ~stall;
    assign off    = result_q[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            load_type_q <= 3'd0;
            result_q    <= 32'd0;
            hold_valid  <= 1'b0;
            data_hold   <= 32'd0;
        end else if (stall) begin
            // Capture the first stalled read word; later read_data may belong to another access.
            if (valid_q && mem_read_q && !hold_valid) begin
                hold_valid <= 1'b1;
                data_hold  <= read_data;
            end
        end else if (flush) begin
            valid_q    <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            valid_q     <= in_valid;
            rd_q        <= in_rd;
            reg_write_q <= in_reg_write;
            mem_read_q  <= in_mem_read;
            load_type_q <= in_load_type;
            result_q    <= in_result;
            hold_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (commit) begin
            instret <= instret + CNT_W'(1);
        end
    end

    assign load_word = hold_valid ? data_hold : read_data;

    always_comb begin
        byte_sel = 8'd0;
        case (off)
            2'd0:    byte_sel = load_word[7:0];
            2'd1:    byte_sel = load_word[15:8];
            2'd2:    byte_sel = load_word[23:16];
            default: byte_sel = load_word[31:24];
        endcase
    end

    assign half_sel = off[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        load_fmt = load_word;
        case (load_type_q)
            LT_LB:   load_fmt = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  load_fmt = {24'd0, byte_sel};
            LT_LH:   load_fmt = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  load_fmt = {16'd0, half_sel};
            default: load_fmt = load_word;
        endcase
    end

    assign wr_data   = mem_read_q ? load_fmt : result_q;
    assign writes_rd = reg_write_q & (rd_q != 5'd0);

    assign is_half = (load_type_q == LT_LH) | (load_type_q == LT_LHU);
    assign is_word = (load_type_q == LT_LW);

    assign wb_en    = commit & writes_rd;
    assign wb_rd    = rd_q;
    assign wb_data  = wr_data;

    // Forwarding stays live through a stall so dependents can still bypass.
    assign fwd_valid = valid_q & writes_rd;
    assign fwd_rd    = rd_q;
    assign fwd_data  = wr_data;

    assign misaligned_load = commit & mem_read_q &
                             ((is_half & off[0]) | (is_word & (off != 2'd0)));

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: stimulus pushes expected commits, a monitor pops them when instret steps.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_read;
    logic [2:0]  in_load_type;
    logic [31:0] in_result;
    logic [31:0] read_data;

    logic        wb_en, fwd_valid, misaligned_load;
    logic [4:0]  wb_rd, fwd_rd;
    logic [31:0] wb_data, fwd_data;
    logic [63:0] instret;

    logic        w_wb_en, w_fwd_valid, w_mis;
    logic [4:0]  w_wb_rd, w_fwd_rd;
    logic [31:0] w_wb_data, w_fwd_data;
    logic [2:0]  w_instret;

    always #5 clk = ~clk;

    mem_wb_stage #(.CNT_W(64)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_load_type(in_load_type), .in_result(in_result), .read_data(read_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .misaligned_load(misaligned_load),
        .instret(instret)
    );

    // Narrow counter copy so the wrap from all-ones to zero is reached quickly.
    mem_wb_stage #(.CNT_W(3)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_load_type(in_load_type), .in_result(in_result), .read_data(read_data),
        .wb_en(w_wb_en), .wb_rd(w_wb_rd), .wb_data(w_wb_data), .fwd_valid(w_fwd_valid),
        .fwd_rd(w_fwd_rd), .fwd_data(w_fwd_data), .misaligned_load(w_mis),
        .instret(w_instret)
    );

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                         input logic [2:0] lt, input logic [31:0] res);
        in_valid     = v;
        in_rd        = rd;
        in_reg_write = rw;
        in_mem_read  = mr;
        in_load_type = lt;
        in_result    = res;
    endtask

    // One instruction followed by a bubble; read_data arrives the cycle after the address.
    task automatic issue(input logic [4:0] rd, input logic rw, input logic mr, input logic [2:0] lt,
                         input logic [31:0] res, input logic [31:0] rdata, input logic e_en,
                         input logic [31:0] e_data, input logic e_mis, input logic e_fwd);
        exp_t e;
        e.en = e_en; e.rd = rd; e.data = e_data; e.mis = e_mis;
        drive(1'b1, rd, rw, mr, lt, res);
        exp_q.push_back(e);
        tick();
        in_valid  = 1'b0;
        read_data = rdata;
        @(negedge clk);
        chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, e_fwd});
        tick();
    endtask

    // Monitor: a step of instret means the previous sampled cycle was a commit.
    initial begin : monitor
        bit          have_prev;
        logic [63:0] cnt;
        logic [63:0] p_instret, delta;
        logic        p_en, p_mis;
        logic [4:0]  p_rd, p_frd;
        logic [31:0] p_data, p_fdata;
        exp_t        e;
        have_prev = 1'b0;
        cnt       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_prev = 1'b0;
                cnt       = '0;
                continue;
            end
            if (have_prev) begin
                delta = instret - p_instret;
                if (delta == 64'd1) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_commit: got rd=%0d data=%0h want no commit", p_rd, p_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_en", {63'd0, p_en}, {63'd0, e.en});
                        chk("wb_rd", {59'd0, p_rd}, {59'd0, e.rd});
                        chk("wb_data", {32'd0, p_data}, {32'd0, e.data});
                        chk("fwd_rd", {59'd0, p_frd}, {59'd0, e.rd});
                        chk("fwd_data", {32'd0, p_fdata}, {32'd0, e.data});
                        chk("misaligned", {63'd0, p_mis}, {63'd0, e.mis});
                    end
                    cnt = cnt + 64'd1;
                    chk("instret", instret, cnt);
                    chk("instret_wrap", {61'd0, w_instret}, {61'd0, cnt[2:0]});
                end else if (delta != 64'd0) begin
                    chk("instret_step", delta, 64'd1);
                end else if (p_en) begin
                    total++;
                    bad++;
                    $display("FAIL wb_en_no_commit: got wb_en=1 want 0 (instret=%0d)", instret);
                end
            end
            have_prev = 1'b1;
            p_instret = instret;
            p_en      = wb_en;
            p_rd      = wb_rd;
            p_data    = wb_data;
            p_frd     = fwd_rd;
            p_fdata   = fwd_data;
            p_mis     = misaligned_load;
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; read_data = 32'h0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst wb_en", {63'd0, wb_en}, 64'd0);
        chk("rst wb_data", {32'd0, wb_data}, 64'd0);
        chk("rst fwd_valid", {63'd0, fwd_valid}, 64'd0);
        chk("rst instret", instret, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst wb_data", {32'd0, wb_data}, 64'd0);
        chk("post-rst misaligned", {63'd0, misaligned_load}, 64'd0);
        tick();

        //     rd     rw    mr    lt      result         read_data     en    data           mis   fwd
        issue(5'd5,  1'b1, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        1'b1, 32'h0000_1234, 1'b0, 1'b1);
        issue(5'd6,  1'b1, 1'b1, 3'b000, 32'h1000_0003, 32'h80FF_7F01, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1);
        issue(5'd6,  1'b1, 1'b1, 3'b100, 32'h1000_0003, 32'h80FF_7F01, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
        issue(5'd10, 1'b1, 1'b1, 3'b000, 32'h1000_0001, 32'h80FF_7F01, 1'b1, 32'h0000_007F, 1'b0, 1'b1);
        issue(5'd11, 1'b1, 1'b1, 3'b001, 32'h1000_0002, 32'h8001_0000, 1'b1, 32'hFFFF_8001, 1'b0, 1'b1);
        issue(5'd12, 1'b1, 1'b1, 3'b001, 32'h1000_0001, 32'h1234_ABCD, 1'b1, 32'hFFFF_ABCD, 1'b1, 1'b1);
        issue(5'd13, 1'b1, 1'b1, 3'b101, 32'h1000_0002, 32'h8001_0000, 1'b1, 32'h0000_8001, 1'b0, 1'b1);
        issue(5'd14, 1'b1, 1'b1, 3'b010, 32'h1000_0002, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        issue(5'd15, 1'b1, 1'b1, 3'b011, 32'h1000_0000, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1);
        issue(5'd0,  1'b1, 1'b0, 3'b000, 32'h0000_0055, 32'h0,        1'b0, 32'h0000_0055, 1'b0, 1'b0);
        issue(5'd3,  1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'h0,        1'b0, 32'h0000_0077, 1'b0, 1'b0);

        // LW held three stalled cycles while read_data changes underneath it.
        begin
            exp_t e;
            e.en = 1'b1; e.rd = 5'd7; e.data = 32'hAAAA_AAAA; e.mis = 1'b0;
            drive(1'b1, 5'd7, 1'b1, 1'b1, 3'b010, 32'h1000_0000);
            exp_q.push_back(e);
            tick();
            in_valid = 1'b0;
            stall = 1'b1;
            read_data = 32'hAAAA_AAAA;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("stall wb_en", {63'd0, wb_en}, 64'd0);
                chk("stall fwd_valid", {63'd0, fwd_valid}, 64'd1);
                chk("stall fwd_data", {32'd0, fwd_data}, {32'd0, 32'hAAAA_AAAA});
                tick();
                read_data = 32'h5555_5555;
            end
            stall = 1'b0;
            tick();
        end

        // Flush replaces a valid instruction with a bubble.
        drive(1'b1, 5'd9, 1'b1, 1'b0, 3'b000, 32'h0000_0999);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush wb_en", {63'd0, wb_en}, 64'd0);
        chk("flush fwd_valid", {63'd0, fwd_valid}, 64'd0);
        tick();

        // Back-to-back ALU ops.
        for (int i = 1; i <= 4; i++) begin
            exp_t e;
            e.en = 1'b1; e.rd = 5'(i); e.data = 32'h1111_1111 * i; e.mis = 1'b0;
            drive(1'b1, 5'(i), 1'b1, 1'b0, 3'b000, 32'h1111_1111 * i);
            exp_q.push_back(e);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("queue drained", 64'(exp_q.size()), 64'd0);

        // Reset asserted while a load is stalled: it must never commit.
        drive(1'b1, 5'd8, 1'b1, 1'b1, 3'b010, 32'h0000_0100);
        tick();
        in_valid = 1'b0;
        stall = 1'b1;
        read_data = 32'h1234_5678;
        @(negedge clk);
        chk("pre-rst fwd_valid", {63'd0, fwd_valid}, 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid-rst wb_en", {63'd0, wb_en}, 64'd0);
        chk("mid-rst wb_data", {32'd0, wb_data}, 64'd0);
        chk("mid-rst fwd_valid", {63'd0, fwd_valid}, 64'd0);
        chk("mid-rst instret", instret, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after-rst wb_en", {63'd0, wb_en}, 64'd0);
            chk("after-rst instret", instret, 64'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
